mem_axi_bridge: RTL and testbench

MEM_AXI_BRIDGE -- requirements
Module: mem_axi_bridge

---
 rtl/def.sv | 20 ++
 rtl/mem_axi_bridge.sv | 128 ++++++++++++
 tb/tb_mem_axi_bridge.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/def.sv
// Shared definitions for the MMU-to-AXI4-Lite memory bridge.
// Request modes, bridge state encoding and AXI response codes.
package def;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WRITE_REQ,
    WRITE_RESP,
    READ_REQ,
    READ_RESP,
    RESPOND
  } state_t;

endpackage

// File: rtl/mem_axi_bridge.sv
// Single-outstanding MMU request to AXI4-Lite master bridge; one transaction at a time,
// requests arriving while busy are ignored. All outputs come straight from flops.
module mem_axi_bridge
  import def::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        request_enable,
  input  logic        req_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        response_enable,
  output logic [31:0] resp_data,
  output logic        bus_error,
  output logic [31:0] awaddr,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [31:0] araddr,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  state_t      state_q;
  state_t      next_state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        accept;

  assign accept = (state_q == IDLE) && request_enable;

  always_comb begin
    next_state = state_q;
    case (state_q)
      IDLE: begin
        if (request_enable) begin
          next_state = (req_mode == MEMREQ_READ) ? READ_REQ : WRITE_REQ;
        end
      end
      WRITE_REQ: begin
        // A channel whose valid is already low has finished its handshake earlier.
        if ((!awvalid || awready) && (!wvalid || wready)) begin
          next_state = WRITE_RESP;
        end
      end
      WRITE_RESP: begin
        if (bvalid) next_state = RESPOND;
      end
      READ_REQ: begin
        if (arready) next_state = READ_RESP;
      end
      READ_RESP: begin
        if (rvalid) next_state = RESPOND;
      end
      RESPOND: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      awvalid         <= 1'b0;
      wvalid          <= 1'b0;
      arvalid         <= 1'b0;
      bready          <= 1'b0;
      rready          <= 1'b0;
      response_enable <= 1'b0;
      bus_error       <= 1'b0;
      resp_data       <= '0;
    end else begin
      state_q <= next_state;

      if (accept) begin
        addr_q  <= req_addr & 32'hFFFF_FFFC;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end

      if (accept && req_mode == MEMREQ_WRITE) awvalid <= 1'b1;
      else if (awvalid && awready)            awvalid <= 1'b0;

      if (accept && req_mode == MEMREQ_WRITE) wvalid <= 1'b1;
      else if (wvalid && wready)              wvalid <= 1'b0;

      if (accept && req_mode == MEMREQ_READ) arvalid <= 1'b1;
      else if (arvalid && arready)           arvalid <= 1'b0;

      bready          <= (next_state == WRITE_RESP);
      rready          <= (next_state == READ_RESP);
      response_enable <= (next_state == RESPOND);

      bus_error <= 1'b0;
      if (state_q == WRITE_RESP && bvalid) begin
        bus_error <= (bresp != AXI_OKAY);
      end
      if (state_q == READ_RESP && rvalid) begin
        bus_error <= (rresp != AXI_OKAY);
        resp_data <= rdata;
      end
    end
  end

  assign awaddr = addr_q;
  assign araddr = addr_q;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;
  assign awprot = 3'b000;
  assign arprot = 3'b000;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Directed bench for mem_axi_bridge: scripted MMU requests against a small
// AXI4-Lite slave whose ready delays and response codes are set per scenario.
module tb_mem_axi_bridge;
  import def::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        request_enable;
  logic        req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        response_enable;
  logic [31:0] resp_data;
  logic        bus_error;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  always #5 clk = ~clk;

  mem_axi_bridge dut (
    .clk(clk), .rstn(rstn),
    .request_enable(request_enable), .req_mode(req_mode), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .response_enable(response_enable), .resp_data(resp_data), .bus_error(bus_error),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Slave configuration, written only by the main sequence.
  int          sl_aw_wait = 0;
  int          sl_w_wait  = 0;
  logic [31:0] sl_rdata   = '0;
  logic [1:0]  sl_rresp   = AXI_OKAY;
  logic [1:0]  sl_bresp   = AXI_OKAY;
  logic        sl_rhold   = 1'b0;

  // Slave observations, written only by the slave process.
  int          n_ar = 0, n_aw = 0, n_w = 0, unstable = 0;
  logic [31:0] cap_araddr = '0, cap_awaddr = '0, cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;

  // Slave: acts at negedges; handshakes noted here complete at the following posedge.
  initial begin
    int          aw_seen = 0, w_seen = 0;
    logic        aw_hs = 0, w_hs = 0, ar_hs = 0, r_hs = 0, b_hs = 0;
    logic        aw_got = 0, w_got = 0;
    logic [31:0] aw_last = '0;
    logic [35:0] w_last = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 1; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(negedge clk);
      if (r_hs) rvalid = 1'b0;
      if (b_hs) bvalid = 1'b0;
      if (ar_hs && !sl_rhold) begin
        rvalid = 1'b1; rdata = sl_rdata; rresp = sl_rresp;
      end
      if (aw_hs) aw_got = 1'b1;
      if (w_hs)  w_got  = 1'b1;
      if (aw_got && w_got) begin
        bvalid = 1'b1; bresp = sl_bresp; aw_got = 1'b0; w_got = 1'b0;
      end
      if (awvalid) begin
        if (aw_seen > 0 && awaddr != aw_last) unstable++;
        awready = (aw_seen >= sl_aw_wait); aw_seen++; aw_last = awaddr;
      end else begin
        awready = 1'b0; aw_seen = 0;
      end
      if (wvalid) begin
        if (w_seen > 0 && {wstrb, wdata} != w_last) unstable++;
        wready = (w_seen >= sl_w_wait); w_seen++; w_last = {wstrb, wdata};
      end else begin
        wready = 1'b0; w_seen = 0;
      end
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      b_hs  = bvalid && bready;
      if (aw_hs) begin n_aw++; cap_awaddr = awaddr; end
      if (w_hs)  begin n_w++;  cap_wdata = wdata; cap_wstrb = wstrb; end
      if (ar_hs) begin n_ar++; cap_araddr = araddr; end
    end
  end

  // Starts at a negedge and returns at the negedge after the response cycle.
  // lat counts cycles from the request cycle to the response cycle, both included.
  task automatic do_req(input logic mode, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, output int lat, output logic err,
                        output logic [31:0] data, output logic tail);
    request_enable = 1'b1; req_mode = mode; req_addr = a; req_wdata = wd; req_wstrb = ws;
    @(negedge clk);
    request_enable = 1'b0;
    lat = 2;
    while (!response_enable && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    err  = bus_error;
    data = resp_data;
    @(negedge clk);
    tail = response_enable | bus_error;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          lat, lat2, first, second, n0, w0;
    logic        err, err2, tail, tail2;
    logic [31:0] data, data2;

    rstn = 1'b0; request_enable = 1'b0; req_mode = MEMREQ_READ;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(negedge clk);
    chk("rst_awvalid", 32'(awvalid), 0);
    chk("rst_wvalid", 32'(wvalid), 0);
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_bready", 32'(bready), 0);
    chk("rst_rready", 32'(rready), 0);
    chk("rst_resp_en", 32'(response_enable), 0);
    chk("rst_bus_err", 32'(bus_error), 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_prot", 32'({awprot, arprot}), 0);
    rstn = 1'b1;
    @(negedge clk);

    // Zero-wait read.
    sl_rdata = 32'hDEAD_BEEF; sl_rresp = AXI_OKAY;
    do_req(MEMREQ_READ, 32'h8000_1004, 0, 0, lat, err, data, tail);
    chk("rd_lat", 32'(lat), 4);
    chk("rd_araddr", cap_araddr, 32'h8000_1004);
    chk("rd_data", data, 32'hDEAD_BEEF);
    chk("rd_err", 32'(err), 0);
    chk("rd_pulse", 32'(tail), 0);
    chk("rd_count", 32'(n_ar), 1);

    // Write with W accepted three cycles before AW.
    sl_aw_wait = 3; sl_w_wait = 0; sl_bresp = AXI_OKAY;
    do_req(MEMREQ_WRITE, 32'h0000_0013, 32'h1234_5678, 4'b0011, lat, err, data, tail);
    chk("wr_lat", 32'(lat), 7);
    chk("wr_awaddr", cap_awaddr, 32'h0000_0010);
    chk("wr_wdata", cap_wdata, 32'h1234_5678);
    chk("wr_wstrb", 32'(cap_wstrb), 32'h3);
    chk("wr_stable", 32'(unstable), 0);
    chk("wr_counts", 32'({n_aw[15:0], n_w[15:0]}), 32'h0001_0001);
    chk("wr_resp_data", data, 32'hDEAD_BEEF);
    chk("wr_err", 32'(err), 0);
    chk("wr_pulse", 32'(tail), 0);

    // Zero-strobe write still goes out, zero-wait latency.
    sl_aw_wait = 0;
    do_req(MEMREQ_WRITE, 32'h2000_0008, 32'hA5A5_5A5A, 4'b0000, lat, err, data, tail);
    chk("wz_lat", 32'(lat), 4);
    chk("wz_awaddr", cap_awaddr, 32'h2000_0008);
    chk("wz_wstrb", 32'(cap_wstrb), 0);
    chk("wz_count", 32'(n_w), 2);

    // Slave error on read.
    sl_rdata = 32'hBAD0_0001; sl_rresp = AXI_SLVERR;
    do_req(MEMREQ_READ, 32'h4000_0002, 0, 0, lat, err, data, tail);
    chk("se_lat", 32'(lat), 4);
    chk("se_araddr", cap_araddr, 32'h4000_0000);
    chk("se_err", 32'(err), 1);
    chk("se_data", data, 32'hBAD0_0001);
    chk("se_pulse", 32'(tail), 0);

    // Request held high across a busy read: only one AR until the bridge is idle again.
    sl_rdata = 32'h1111_2222; sl_rresp = AXI_OKAY;
    n0 = n_ar; first = -1; second = -1;
    request_enable = 1'b1; req_mode = MEMREQ_READ; req_addr = 32'h0000_0100;
    for (int c = 0; c < 12; c++) begin
      if (c == 5) request_enable = 1'b0;
      if (c == 3) chk("hold_single_ar", 32'(n_ar - n0), 1);
      if (response_enable) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      @(negedge clk);
    end
    chk("hold_first", 32'(first), 3);
    chk("hold_second", 32'(second), 7);
    chk("hold_ar_total", 32'(n_ar - n0), 2);

    // MMU-style back-to-back: next request in the cycle after response_enable.
    n0 = n_ar; w0 = n_aw;
    sl_rdata = 32'hCAFE_F00D;
    do_req(MEMREQ_WRITE, 32'h3000_0004, 32'h0F0F_0F0F, 4'b1111, lat, err, data, tail);
    do_req(MEMREQ_READ, 32'h3000_0004, 0, 0, lat2, err2, data2, tail2);
    chk("b2b_wr_lat", 32'(lat), 4);
    chk("b2b_rd_lat", 32'(lat2), 4);
    chk("b2b_rd_data", data2, 32'hCAFE_F00D);
    chk("b2b_counts", 32'({16'(n_aw - w0), 16'(n_ar - n0)}), 32'h0001_0001);

    // Reset while waiting for read data.
    sl_rhold = 1'b1;
    request_enable = 1'b1; req_mode = MEMREQ_READ; req_addr = 32'h5000_0000;
    @(negedge clk);
    request_enable = 1'b0;
    @(negedge clk);
    chk("mid_rready", 32'(rready), 1);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_arvalid", 32'(arvalid), 0);
    chk("mid_rst_rready", 32'(rready), 0);
    chk("mid_rst_resp_en", 32'(response_enable), 0);
    chk("mid_rst_resp_data", resp_data, 0);
    chk("mid_rst_bus_err", 32'(bus_error), 0);
    rstn = 1'b1; sl_rhold = 1'b0;
    @(negedge clk);
    sl_rdata = 32'h0BAD_F00D;
    do_req(MEMREQ_READ, 32'h5000_0010, 0, 0, lat, err, data, tail);
    chk("post_rst_lat", 32'(lat), 4);
    chk("post_rst_data", data, 32'h0BAD_F00D);
    chk("post_rst_araddr", cap_araddr, 32'h5000_0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
